// File: rtl/vic20_pkg.sv
// Shared timing constants and access types for the VIC-20 RAM arbiter.
package vic20_pkg;

    localparam int DIV        = 25;
    localparam int LD_SLOT    = 23;
    localparam int RD_LATENCY = 2;

    typedef enum logic [1:0] {
        G_NONE,
        G_CPU,
        G_VID,
        G_LD
    } grant_t;

    typedef struct packed {
        grant_t gnt;
        logic   we;
    } access_t;

endpackage

// File: rtl/ram_slot_timer.sv
// Slot counter for the shared RAM and the CPU halt handshake, which only
// changes state on a CPU-cycle boundary.
module ram_slot_timer #(
    parameter int DIV    = vic20_pkg::DIV,
    parameter int SLOT_W = $clog2(DIV)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_halt,
    output logic [SLOT_W-1:0] slot,
    output logic              cpu_clken,
    output logic              cpu_halted
);

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(DIV - 1);

    logic last_slot;

    assign last_slot = (slot == LAST_SLOT);

    // A running CPU always finishes its cycle; a halted one resumes as soon
    // as the loader lets go at a boundary.
    assign cpu_clken = last_slot && !(cpu_halted && ld_halt);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot       <= '0;
            cpu_halted <= 1'b0;
        end else begin
            slot <= last_slot ? '0 : slot + 1'b1;
            if (last_slot) begin
                cpu_halted <= ld_halt;
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Time-slotted arbiter sharing one single-port RAM between the CPU, the
// video fetcher and the SPI loader.
module ram_arbiter #(
    parameter int DIV     = vic20_pkg::DIV,
    parameter int LD_SLOT = vic20_pkg::LD_SLOT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        cpu_clken,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_halted,
    input  logic        vid_req,
    input  logic [15:0] vid_addr,
    output logic        vid_ack,
    output logic        vid_valid,
    output logic [7:0]  vid_rdata,
    input  logic        ld_req,
    input  logic        ld_we,
    input  logic [15:0] ld_addr,
    input  logic [7:0]  ld_wdata,
    input  logic        ld_halt,
    output logic        ld_ack,
    output logic        ld_valid,
    output logic [7:0]  ld_rdata,
    output logic [15:0] ram_addr,
    output logic        ram_we,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata
);

    import vic20_pkg::*;

    localparam int SLOT_W = $clog2(DIV);

    logic [SLOT_W-1:0] slot;
    grant_t            gnt;
    logic              issue_we;
    access_t           pipe_q [RD_LATENCY];
    access_t           done;

    ram_slot_timer #(
        .DIV    (DIV),
        .SLOT_W (SLOT_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .ld_halt    (ld_halt),
        .slot       (slot),
        .cpu_clken  (cpu_clken),
        .cpu_halted (cpu_halted)
    );

    // NOTE: gnt gets its default before any branch so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        gnt = G_NONE;
        if (slot == '0 && !cpu_halted) begin
            gnt = G_CPU;
        end else if (ld_req && slot == SLOT_W'(LD_SLOT)) begin
            gnt = G_LD;
        end else if (vid_req) begin
            gnt = G_VID;
        end else if (ld_req) begin
            gnt = G_LD;
        end
    end

    assign vid_ack  = (gnt == G_VID);
    assign ld_ack   = (gnt == G_LD);
    assign issue_we = (gnt == G_CPU) ? cpu_we : (gnt == G_LD) ? ld_we : 1'b0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_wdata <= '0;
            cpu_rdata <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            ram_we <= issue_we;
            case (gnt)
                G_CPU: begin
                    ram_addr  <= cpu_addr;
                    ram_wdata <= cpu_wdata;
                end
                G_VID: ram_addr <= vid_addr;
                G_LD: begin
                    ram_addr  <= ld_addr;
                    ram_wdata <= ld_wdata;
                end
                default: ;
            endcase
            pipe_q[0] <= '{gnt: gnt, we: issue_we};
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
            if (done.gnt == G_CPU && !done.we) begin
                cpu_rdata <= ram_rdata;
            end
        end
    end

    assign done = pipe_q[RD_LATENCY-1];

    // Read data is presented straight from the RAM in its valid cycle and
    // forced to zero otherwise, so the fixed two-clock latency holds.
    assign vid_valid = (done.gnt == G_VID);
    assign ld_valid  = (done.gnt == G_LD) && !done.we;
    assign vid_rdata = vid_valid ? ram_rdata : '0;
    assign ld_rdata  = ld_valid ? ram_rdata : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: idle timing, CPU write/read, contention,
// loader halt and reset in the middle of a video read.
module tb_ram_arbiter;

    logic        clk;
    logic        reset;
    logic        cpu_clken;
    logic [15:0] cpu_addr;
    logic        cpu_we;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_halted;
    logic        vid_req;
    logic [15:0] vid_addr;
    logic        vid_ack;
    logic        vid_valid;
    logic [7:0]  vid_rdata;
    logic        ld_req;
    logic        ld_we;
    logic [15:0] ld_addr;
    logic [7:0]  ld_wdata;
    logic        ld_halt;
    logic        ld_ack;
    logic        ld_valid;
    logic [7:0]  ld_rdata;
    logic [15:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    int n_assert;
    int n_fail;
    int slot_m;

    ram_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_clken  (cpu_clken),
        .cpu_addr   (cpu_addr),
        .cpu_we     (cpu_we),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_halted (cpu_halted),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .vid_ack    (vid_ack),
        .vid_valid  (vid_valid),
        .vid_rdata  (vid_rdata),
        .ld_req     (ld_req),
        .ld_we      (ld_we),
        .ld_addr    (ld_addr),
        .ld_wdata   (ld_wdata),
        .ld_halt    (ld_halt),
        .ld_ack     (ld_ack),
        .ld_valid   (ld_valid),
        .ld_rdata   (ld_rdata),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port RAM; a few locations carry preset contents.
    bit [7:0] mem     [65536];
    bit       written [65536];

    function automatic logic [7:0] preset(input logic [15:0] a);
        case (a)
            16'h0000: return 8'h33;
            16'h2000: return 8'hC3;
            16'h3000: return 8'h7E;
            default:  return 8'h00;
        endcase
    endfunction

    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr]     <= ram_wdata;
            written[ram_addr] <= 1'b1;
        end
        ram_rdata <= written[ram_addr] ? mem[ram_addr] : preset(ram_addr);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        slot_m = (slot_m + 1) % 25;
    endtask

    task automatic goto_slot(input int s);
        for (int k = 0; k < 25 && slot_m != s; k++) step();
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        slot_m    = 0;
        reset     = 1'b1;
        cpu_addr  = '0;
        cpu_we    = 1'b0;
        cpu_wdata = '0;
        vid_req   = 1'b0;
        vid_addr  = '0;
        ld_req    = 1'b0;
        ld_we     = 1'b0;
        ld_addr   = '0;
        ld_wdata  = '0;
        ld_halt   = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_clken", cpu_clken, 0);
        check("rst_halted", cpu_halted, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_wdata", ram_wdata, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_vid_valid", vid_valid, 0);
        check("rst_ld_valid", ld_valid, 0);

        reset  = 1'b0;
        slot_m = 0;
        for (int c = 0; c < 50; c++) begin
            check("idle_clken", cpu_clken, (slot_m == 24));
            check("idle_ram_we", ram_we, 0);
            step();
        end

        // CPU write then read back of 0x1000
        cpu_addr  = 16'h1000;
        cpu_we    = 1'b1;
        cpu_wdata = 8'h5A;
        step();
        check("wr_ram_we", ram_we, 1);
        check("wr_ram_addr", ram_addr, 16'h1000);
        check("wr_ram_wdata", ram_wdata, 8'h5A);
        cpu_we = 1'b0;
        step();
        check("wr_ram_we_pulse", ram_we, 0);
        step();
        check("wr_rdata_kept", cpu_rdata, 8'h33);
        goto_slot(0);
        step();
        check("rd_ram_addr", ram_addr, 16'h1000);
        check("rd_ram_we", ram_we, 0);
        step();
        step();
        check("rd_cpu_rdata", cpu_rdata, 8'h5A);

        // Video and loader contend for a whole frame
        goto_slot(0);
        vid_req  = 1'b1;
        vid_addr = 16'h3000;
        ld_req   = 1'b1;
        ld_we    = 1'b0;
        ld_addr  = 16'h2000;
        for (int s = 0; s < 25; s++) begin
            if (s == 24) ld_req = 1'b0;
            check("cont_vid_ack", vid_ack, (s != 0 && s != 23));
            check("cont_ld_ack", ld_ack, (s == 23));
            if (s == 2) check("cont_vid_valid_gap", vid_valid, 0);
            if (s == 3) begin
                check("cont_vid_valid", vid_valid, 1);
                check("cont_vid_rdata", vid_rdata, 8'h7E);
            end
            if (s == 24) begin
                check("cont_ld_ram_addr", ram_addr, 16'h2000);
                check("cont_ld_ram_we", ram_we, 0);
            end
            step();
        end
        check("cont_ld_valid", ld_valid, 1);
        check("cont_ld_rdata", ld_rdata, 8'hC3);
        check("cont_vid_valid_ld", vid_valid, 0);
        check("cont_vid_ack_s0", vid_ack, 0);
        step();
        check("cont_ld_valid_pulse", ld_valid, 0);
        check("cont_vid_valid_next", vid_valid, 1);
        vid_req = 1'b0;

        // Loader halts the CPU and writes in slot 0
        goto_slot(10);
        ld_halt = 1'b1;
        goto_slot(24);
        check("halt_last_clken", cpu_clken, 1);
        check("halt_not_yet", cpu_halted, 0);
        step();
        check("halt_set", cpu_halted, 1);
        ld_req    = 1'b1;
        ld_we     = 1'b1;
        ld_addr   = 16'h0000;
        ld_wdata  = 8'h99;
        cpu_addr  = 16'h1000;
        cpu_we    = 1'b1;
        cpu_wdata = 8'hEE;
        check("halt_ld_ack_s0", ld_ack, 1);
        step();
        ld_req = 1'b0;
        ld_we  = 1'b0;
        check("halt_ld_ram_we", ram_we, 1);
        check("halt_ld_ram_addr", ram_addr, 16'h0000);
        check("halt_ld_ram_wdata", ram_wdata, 8'h99);
        step();
        check("halt_ld_no_valid", ld_valid, 0);
        check("halt_ram_we_pulse", ram_we, 0);
        goto_slot(24);
        check("halt_no_clken", cpu_clken, 0);
        check("halt_held", cpu_halted, 1);
        step();
        step();
        check("halt_cpu_ignored", ram_we, 0);
        cpu_we = 1'b0;
        goto_slot(5);
        ld_halt = 1'b0;
        goto_slot(24);
        check("release_clken", cpu_clken, 1);
        step();
        check("release_halted", cpu_halted, 0);
        cpu_addr = 16'h0000;
        step();
        step();
        step();
        check("release_cpu_rdata", cpu_rdata, 8'h99);

        // Reset one clock after a video grant
        goto_slot(5);
        vid_req  = 1'b1;
        vid_addr = 16'h3000;
        check("mid_vid_ack", vid_ack, 1);
        step();
        vid_req = 1'b0;
        reset   = 1'b1;
        #1;
        check("mid_vid_valid", vid_valid, 0);
        check("mid_vid_ack_clr", vid_ack, 0);
        check("mid_ram_addr", ram_addr, 0);
        check("mid_ram_we", ram_we, 0);
        check("mid_ram_wdata", ram_wdata, 0);
        check("mid_cpu_rdata", cpu_rdata, 0);
        check("mid_halted", cpu_halted, 0);
        check("mid_ld_valid", ld_valid, 0);
        check("mid_clken", cpu_clken, 0);
        @(negedge clk);
        check("mid_hold_vid_valid", vid_valid, 0);
        reset  = 1'b0;
        slot_m = 0;
        for (int c = 0; c < 25; c++) begin
            check("post_rst_clken", cpu_clken, (slot_m == 24));
            check("post_rst_vid_valid", vid_valid, 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter DIV, default 25, meaning clk cycles per CPU cycle (25 MHz to 1 MHz).
REQ-002 SHALL have parameter LD_SLOT, default 23, meaning the slot in which the loader has priority over video.
REQ-003 SHALL have port clk, input, 1 bit: single system clock (25 MHz); all logic in this one clock domain.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have the CPU-side ports:
- cpu_clken out 1: CPU/VIA advance strobe.
- cpu_addr in 16, cpu_we in 1, cpu_wdata in 8: registered CPU bus.
- cpu_rdata out 8: CPU read data.
- cpu_halted out 1: CPU stopped by loader.
REQ-006 SHALL have the video requester ports: vid_req in 1, vid_addr in 16, vid_ack out 1, vid_valid out 1, vid_rdata out 8.
REQ-007 SHALL have the loader (ESP32 SPI DMA) ports: ld_req in 1, ld_we in 1, ld_addr in 16, ld_wdata in 8, ld_halt in 1, ld_ack out 1, ld_valid out 1, ld_rdata out 8.
REQ-008 SHALL have the single-port RAM ports: ram_addr out 16, ram_we out 1, ram_wdata out 8, ram_rdata in 8. RAM read latency is 1 clk.

Function
REQ-009 SHALL keep a slot counter that counts 0..DIV-1 and wraps to 0.
REQ-010 SHALL assert cpu_clken for exactly one clk when slot==DIV-1 and the CPU is not halted; it SHALL stay 0 at all other times.
REQ-011 SHALL reserve slot 0 for the CPU when not halted: the CPU access is issued unconditionally and cpu_addr/cpu_we/cpu_wdata are sampled in that slot.
REQ-012 SHALL capture cpu_rdata at slot 2 and hold it until the next slot 2; a CPU write leaves cpu_rdata unchanged.
REQ-013 SHALL grant at most one of video or loader per clk in slots 1..DIV-1, plus slot 0 while halted. Priority is video over loader, except in slot LD_SLOT, where loader wins over video.
REQ-014 SHALL pulse the ack for one clk in the grant cycle N; ram_addr/ram_we/ram_wdata SHALL be registered at the end of cycle N.
REQ-015 SHALL, for a granted read, assert valid with rdata in cycle N+2. Latency is fixed at 2 clk and valid lasts one clk.
REQ-016 SHALL accept back-to-back grants: the requester holds req/addr stable until ack; if req stays high after ack, it is a new request.
REQ-017 SHALL pulse ram_we for exactly one clk per granted write; ram_we SHALL be 0 in idle cycles and for reads.
REQ-018 SHALL produce no valid pulse for loader writes.
REQ-019 SHALL handle ld_halt as follows:
- Sampled only at slot DIV-1; if 1, cpu_clken is suppressed and cpu_halted=1 from the next slot 0.
- Released at the first slot DIV-1 where ld_halt=0; cpu_clken fires in that same cycle.
- The CPU never sees a partial cycle.
REQ-020 SHALL, while halted, issue no CPU access and ignore cpu_we.
REQ-021 SHALL block video/loader grants in slot 0 while not halted; pending requests wait and receive no ack.
REQ-022 SHALL keep address and data sources of the RAM port output registers from the granted requester only.

Reset
REQ-023 SHALL on reset clear slot, cpu_clken, cpu_rdata, cpu_halted, ram_addr, ram_we, ram_wdata, all acks, valids and rdata to 0.
REQ-024 SHALL drop any read in flight at reset with no valid; after reset release the first cpu_clken occurs at slot DIV-1.

Structure
REQ-025 SHALL place DIV, LD_SLOT, the read latency (2) and the grant enum {G_NONE, G_CPU, G_VID, G_LD} in shared package vic20_pkg.
REQ-026 SHALL implement the slot counter and halt-boundary logic in a sub-module ram_slot_timer (outputs slot, cpu_clken, cpu_halted).

Verification
REQ-027 SHALL verify idle after reset: cpu_clken pulses every 25 clk, first at clk 24; ram_we stays 0.
REQ-028 SHALL verify a CPU write: cpu_addr=0x1000, cpu_we=1, cpu_wdata=0x5A at slot 0 -> ram_we=1 for 1 clk with ram_addr=0x1000 and ram_wdata=0x5A. A later CPU read of 0x1000 -> cpu_rdata=0x5A at slot 2.
REQ-029 SHALL verify contention: vid_req held continuously, with an ld_req read of 0x2000 pending -> ld_ack only in slot 23, ld_valid 2 clk later. vid_ack is never in slot 0 and fires in every other slot.
REQ-030 SHALL verify halt: ld_halt asserted at slot 10 -> the next cpu_clken still fires, then none. ld_write to 0x0000 is acked in slot 0. Deassert -> cpu_clken resumes at slot 24.
REQ-031 SHALL verify reset mid-read: reset 1 clk after vid_ack -> no vid_valid, all outputs 0, counter restarts at 0.
